mem_access: RTL and testbench

Memory-access stage of the RV32I pipeline core, sitting between the execute (ALU) stage and write-back. It latches the execute stage's load/store request and drives a single-outstanding memory bus. It lane-aligns store data and strobes, and extracts and sign/zero-extends load data. While an access is in flight it asserts STALL to the upstream stages, and it supplies the M-stage forwarding bus.

---
 rtl/mem_access_if.sv | 24 ++
 rtl/mem_access.sv | 200 ++++++++++++++++++++
 tb/tb_mem_access.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Memory command/response bus between the memory-access stage and the data memory.
// Single outstanding command; reads return one word on MEM_RD_VALID.
interface mem_access_if;
    logic        MEM_CMD_VALID;
    logic        MEM_CMD_READY;
    logic        MEM_CMD_WRITE;
    logic [31:0] MEM_CMD_ADDR;
    logic [3:0]  MEM_CMD_STRB;
    logic [31:0] MEM_CMD_WDATA;
    logic        MEM_RD_VALID;
    logic [31:0] MEM_RD_DATA;

    // Pipeline side issues commands and consumes read data
    modport master (
        output MEM_CMD_VALID, MEM_CMD_WRITE, MEM_CMD_ADDR, MEM_CMD_STRB, MEM_CMD_WDATA,
        input  MEM_CMD_READY, MEM_RD_VALID, MEM_RD_DATA
    );

    // Memory side accepts commands and returns read data
    modport slave (
        input  MEM_CMD_VALID, MEM_CMD_WRITE, MEM_CMD_ADDR, MEM_CMD_STRB, MEM_CMD_WDATA,
        output MEM_CMD_READY, MEM_RD_VALID, MEM_RD_DATA
    );
endinterface

// File: rtl/mem_access.sv
// RV32I memory-access stage: latches the execute-stage request, runs one bus
// access at a time, lane-aligns stores, extracts/extends loads and stalls the
// upstream pipeline while an access is in flight.
module mem_access (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] A_PC,
    input  logic [31:0] A_INST,
    input  logic        A_VALID,
    input  logic [4:0]  A_REG_D,
    input  logic [31:0] A_REG_D_V,
    input  logic        A_LOAD_RDEN,
    input  logic [31:0] A_LOAD_ADDR,
    input  logic [1:0]  A_LOAD_SIZE,
    input  logic        A_LOAD_SIGNED,
    input  logic        A_STORE_WREN,
    input  logic [31:0] A_STORE_ADDR,
    input  logic [3:0]  A_STORE_STRB,
    input  logic [31:0] A_STORE_DATA,
    output logic        STALL,
    mem_access_if.master mem,
    output logic [31:0] M_PC,
    output logic [31:0] M_INST,
    output logic        M_VALID,
    output logic [4:0]  M_REG_D,
    output logic [31:0] M_REG_D_V,
    output logic        M_MISALIGN,
    output logic        FWD_M_VALID,
    output logic [4:0]  FWD_M_REG_D,
    output logic [31:0] FWD_M_REG_D_V
);

    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        valid_q, valid_d;
    logic [4:0]  reg_d_q, reg_d_d;
    logic [31:0] reg_d_v_q, reg_d_v_d;
    logic        is_load_q, is_load_d;
    logic        is_store_q, is_store_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        sign_q, sign_d;
    logic [3:0]  strb_q, strb_d;
    logic [31:0] wdata_q, wdata_d;
    logic        misalign_q, misalign_d;
    logic [31:0] res_q, res_d;

    // Request decode of the incoming execute-stage instruction (load wins over store)
    logic        acc_load, acc_store, acc_misal;
    logic [31:0] acc_addr;
    logic [1:0]  acc_size, acc_lane;

    always_comb begin
        acc_load  = A_VALID & A_LOAD_RDEN;
        acc_store = A_VALID & A_STORE_WREN & ~A_LOAD_RDEN;
        acc_addr  = A_LOAD_RDEN ? A_LOAD_ADDR : A_STORE_ADDR;
        acc_lane  = acc_addr[1:0];
        // Store width is implied by the unshifted strobe pattern
        if (A_LOAD_RDEN)          acc_size = A_LOAD_SIZE;
        else if (A_STORE_STRB[3]) acc_size = 2'b10;
        else if (A_STORE_STRB[1]) acc_size = 2'b01;
        else                      acc_size = 2'b00;
        acc_misal = 1'b0;
        if (acc_load | acc_store) begin
            if (acc_size[1])           acc_misal = (acc_lane != 2'b00);
            else if (acc_size == 2'b01) acc_misal = acc_lane[0];
        end
    end

    // Load data extraction and extension from the returned word
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] load_val;

    always_comb begin
        rd_shift = mem.MEM_RD_DATA >> {addr_q[1:0], 3'b000};
        rd_half  = addr_q[1] ? mem.MEM_RD_DATA[31:16] : mem.MEM_RD_DATA[15:0];
        if (size_q[1])
            load_val = mem.MEM_RD_DATA;
        else if (size_q == 2'b01)
            load_val = {{16{sign_q & rd_half[15]}}, rd_half};
        else
            load_val = {{24{sign_q & rd_shift[7]}}, rd_shift[7:0]};
    end

    // Next-state: latch in IDLE, wait for acceptance in CMD, capture data in RESP
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        valid_d    = valid_q;
        reg_d_d    = reg_d_q;
        reg_d_v_d  = reg_d_v_q;
        is_load_d  = is_load_q;
        is_store_d = is_store_q;
        addr_d     = addr_q;
        size_d     = size_q;
        sign_d     = sign_q;
        strb_d     = strb_q;
        wdata_d    = wdata_q;
        misalign_d = misalign_q;
        res_d      = res_q;
        case (state_q)
            IDLE: begin
                pc_d       = A_PC;
                inst_d     = A_INST;
                valid_d    = A_VALID;
                reg_d_d    = A_REG_D;
                reg_d_v_d  = A_REG_D_V;
                is_load_d  = acc_load;
                is_store_d = acc_store;
                addr_d     = acc_addr;
                size_d     = acc_size;
                sign_d     = A_LOAD_SIGNED;
                strb_d     = acc_store ? (A_STORE_STRB << acc_lane) : 4'b0000;
                wdata_d    = acc_store ? (A_STORE_DATA << {acc_lane, 3'b000}) : 32'h0;
                misalign_d = acc_misal;
                // Cleared here so a suppressed (misaligned) load reads back as 0
                res_d      = 32'h0;
                if ((acc_load | acc_store) & ~acc_misal)
                    state_d = CMD;
            end
            CMD: begin
                if (mem.MEM_CMD_READY)
                    state_d = is_load_q ? RESP : IDLE;
            end
            RESP: begin
                if (mem.MEM_RD_VALID) begin
                    res_d   = load_val;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and stage register; reset clears everything so all outputs read 0
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            pc_q       <= 32'h0;
            inst_q     <= 32'h0;
            valid_q    <= 1'b0;
            reg_d_q    <= 5'h0;
            reg_d_v_q  <= 32'h0;
            is_load_q  <= 1'b0;
            is_store_q <= 1'b0;
            addr_q     <= 32'h0;
            size_q     <= 2'b00;
            sign_q     <= 1'b0;
            strb_q     <= 4'b0000;
            wdata_q    <= 32'h0;
            misalign_q <= 1'b0;
            res_q      <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            valid_q    <= valid_d;
            reg_d_q    <= reg_d_d;
            reg_d_v_q  <= reg_d_v_d;
            is_load_q  <= is_load_d;
            is_store_q <= is_store_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            strb_q     <= strb_d;
            wdata_q    <= wdata_d;
            misalign_q <= misalign_d;
            res_q      <= res_d;
        end
    end

    // Bus command is a direct view of the latched request, stable while in CMD
    always_comb begin
        STALL             = (state_q != IDLE);
        mem.MEM_CMD_VALID = (state_q == CMD);
        mem.MEM_CMD_WRITE = is_store_q;
        mem.MEM_CMD_ADDR  = {addr_q[31:2], 2'b00};
        mem.MEM_CMD_STRB  = strb_q;
        mem.MEM_CMD_WDATA = wdata_q;
    end

    // M-stage and forwarding outputs; nothing is valid while its access is pending
    always_comb begin
        M_PC          = pc_q;
        M_INST        = inst_q;
        M_VALID       = valid_q & (state_q == IDLE);
        M_REG_D       = reg_d_q;
        M_REG_D_V     = is_load_q ? res_q : reg_d_v_q;
        M_MISALIGN    = misalign_q;
        FWD_M_VALID   = M_VALID;
        FWD_M_REG_D   = M_REG_D;
        FWD_M_REG_D_V = M_REG_D_V;
    end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: expected bus commands and load results are
// queued when stimulus is driven and popped when the DUT presents them.
module tb_mem_access;

    logic        CLK, RST;
    logic [31:0] A_PC, A_INST, A_REG_D_V, A_LOAD_ADDR, A_STORE_ADDR, A_STORE_DATA;
    logic        A_VALID, A_LOAD_RDEN, A_LOAD_SIGNED, A_STORE_WREN;
    logic [4:0]  A_REG_D;
    logic [1:0]  A_LOAD_SIZE;
    logic [3:0]  A_STORE_STRB;
    logic        STALL, M_VALID, M_MISALIGN, FWD_M_VALID;
    logic [31:0] M_PC, M_INST, M_REG_D_V, FWD_M_REG_D_V;
    logic [4:0]  M_REG_D, FWD_M_REG_D;

    mem_access_if bus ();

    mem_access dut (
        .CLK(CLK), .RST(RST),
        .A_PC(A_PC), .A_INST(A_INST), .A_VALID(A_VALID),
        .A_REG_D(A_REG_D), .A_REG_D_V(A_REG_D_V),
        .A_LOAD_RDEN(A_LOAD_RDEN), .A_LOAD_ADDR(A_LOAD_ADDR),
        .A_LOAD_SIZE(A_LOAD_SIZE), .A_LOAD_SIGNED(A_LOAD_SIGNED),
        .A_STORE_WREN(A_STORE_WREN), .A_STORE_ADDR(A_STORE_ADDR),
        .A_STORE_STRB(A_STORE_STRB), .A_STORE_DATA(A_STORE_DATA),
        .STALL(STALL), .mem(bus.master),
        .M_PC(M_PC), .M_INST(M_INST), .M_VALID(M_VALID),
        .M_REG_D(M_REG_D), .M_REG_D_V(M_REG_D_V), .M_MISALIGN(M_MISALIGN),
        .FWD_M_VALID(FWD_M_VALID), .FWD_M_REG_D(FWD_M_REG_D),
        .FWD_M_REG_D_V(FWD_M_REG_D_V)
    );

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] res_q[$];
    int          errors = 0;
    int          checks = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare the command currently on the bus against the next queued one
    task automatic chk_cmd(input string tag);
        cmd_t c;
        if (cmd_q.size() == 0) begin
            chk({tag, " queue"}, 32'd0, 32'd1);
        end else begin
            c = cmd_q.pop_front();
            chk({tag, " valid"}, {31'd0, bus.MEM_CMD_VALID}, 32'd1);
            chk({tag, " write"}, {31'd0, bus.MEM_CMD_WRITE}, {31'd0, c.write});
            chk({tag, " addr"},  bus.MEM_CMD_ADDR, c.addr);
            chk({tag, " strb"},  {28'd0, bus.MEM_CMD_STRB}, {28'd0, c.strb});
            chk({tag, " wdata"}, bus.MEM_CMD_WDATA, c.wdata);
        end
    endtask

    // Issue one load; delay = cycles READY is held low, glitch = RD_VALID during CMD
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] size,
                           input logic sgn, input logic [31:0] rdata, input int delay,
                           input logic glitch, input logic [31:0] exp);
        logic [31:0] held_addr;
        logic [31:0] r;
        cmd_q.push_back('{1'b0, {addr[31:2], 2'b00}, 4'b0000, 32'h0});
        res_q.push_back(exp);
        A_VALID = 1'b1; A_LOAD_RDEN = 1'b1; A_LOAD_ADDR = addr;
        A_LOAD_SIZE = size; A_LOAD_SIGNED = sgn; A_REG_D = 5'd7;
        bus.MEM_CMD_READY = (delay == 0);
        tick();
        A_VALID = 1'b0; A_LOAD_RDEN = 1'b0; A_STORE_WREN = 1'b0;
        chk({tag, " stall"}, {31'd0, STALL}, 32'd1);
        chk({tag, " mvalid pend"}, {31'd0, M_VALID}, 32'd0);
        held_addr = bus.MEM_CMD_ADDR;
        chk_cmd(tag);
        for (int i = 0; i < delay; i++) begin
            tick();
            chk({tag, " hold valid"}, {31'd0, bus.MEM_CMD_VALID}, 32'd1);
            chk({tag, " hold stall"}, {31'd0, STALL}, 32'd1);
            chk({tag, " hold addr"}, bus.MEM_CMD_ADDR, held_addr);
        end
        bus.MEM_CMD_READY = 1'b1;
        if (glitch) begin
            bus.MEM_RD_VALID = 1'b1; bus.MEM_RD_DATA = 32'hDEADBEEF;
        end
        tick();
        chk({tag, " resp stall"}, {31'd0, STALL}, 32'd1);
        chk({tag, " resp cmdv"}, {31'd0, bus.MEM_CMD_VALID}, 32'd0);
        bus.MEM_RD_VALID = 1'b1; bus.MEM_RD_DATA = rdata;
        tick();
        bus.MEM_RD_VALID = 1'b0;
        r = res_q.pop_front();
        chk({tag, " stall done"}, {31'd0, STALL}, 32'd0);
        chk({tag, " mvalid"}, {31'd0, M_VALID}, 32'd1);
        chk({tag, " result"}, M_REG_D_V, r);
        chk({tag, " fwd"}, FWD_M_REG_D_V, r);
    endtask

    initial begin
        RST = 1'b1;
        A_PC = '0; A_INST = '0; A_VALID = 1'b0; A_REG_D = '0; A_REG_D_V = '0;
        A_LOAD_RDEN = 1'b0; A_LOAD_ADDR = '0; A_LOAD_SIZE = '0; A_LOAD_SIGNED = 1'b0;
        A_STORE_WREN = 1'b0; A_STORE_ADDR = '0; A_STORE_STRB = '0; A_STORE_DATA = '0;
        bus.MEM_CMD_READY = 1'b0; bus.MEM_RD_VALID = 1'b0; bus.MEM_RD_DATA = '0;
        #2;
        chk("rst stall", {31'd0, STALL}, 32'd0);
        chk("rst cmdv", {31'd0, bus.MEM_CMD_VALID}, 32'd0);
        chk("rst mvalid", {31'd0, M_VALID}, 32'd0);
        chk("rst result", M_REG_D_V, 32'd0);
        #10 RST = 1'b0;
        tick();

        // Non-memory add: x5 = 0x1234
        A_VALID = 1'b1; A_REG_D = 5'd5; A_REG_D_V = 32'h1234;
        A_PC = 32'h0000_0040; A_INST = 32'h0062_82B3;
        tick();
        chk("add mvalid", {31'd0, M_VALID}, 32'd1);
        chk("add value", M_REG_D_V, 32'h1234);
        chk("add regd", {27'd0, M_REG_D}, 32'd5);
        chk("add pc", M_PC, 32'h40);
        chk("add fwd regd", {27'd0, FWD_M_REG_D}, 32'd5);
        chk("add stall", {31'd0, STALL}, 32'd0);

        // sb 0xAB to 0x1003 with READY already high
        cmd_q.push_back('{1'b1, 32'h1000, 4'b1000, 32'hAB00_0000});
        A_STORE_WREN = 1'b1; A_STORE_ADDR = 32'h1003; A_STORE_STRB = 4'b0001;
        A_STORE_DATA = 32'h0000_00AB; A_REG_D_V = 32'h0000_0999;
        bus.MEM_CMD_READY = 1'b1;
        tick();
        A_VALID = 1'b0; A_STORE_WREN = 1'b0;
        chk("sb stall", {31'd0, STALL}, 32'd1);
        chk_cmd("sb cmd");
        tick();
        chk("sb stall end", {31'd0, STALL}, 32'd0);
        chk("sb cmdv end", {31'd0, bus.MEM_CMD_VALID}, 32'd0);
        chk("sb mvalid", {31'd0, M_VALID}, 32'd1);
        tick();

        do_load("lb",  32'h2002, 2'b00, 1'b1, 32'h00F0_0000, 0, 1'b1, 32'hFFFF_FFF0);
        do_load("lbu", 32'h2002, 2'b00, 1'b0, 32'h00F0_0000, 0, 1'b0, 32'h0000_00F0);
        do_load("lh",  32'h2002, 2'b01, 1'b1, 32'h8001_0000, 3, 1'b0, 32'hFFFF_8001);
        do_load("lhu", 32'h2000, 2'b01, 1'b0, 32'h1234_F00D, 0, 1'b0, 32'h0000_F00D);
        // Load and store both requested: the load must be the one issued
        A_STORE_WREN = 1'b1; A_STORE_ADDR = 32'h5000; A_STORE_STRB = 4'b1111;
        A_STORE_DATA = 32'h5555_5555;
        do_load("lw prio", 32'h2004, 2'b10, 1'b1, 32'h89AB_CDEF, 1, 1'b0, 32'h89AB_CDEF);

        // Misaligned lw from 0x3001 is suppressed
        A_VALID = 1'b1; A_LOAD_RDEN = 1'b1; A_LOAD_ADDR = 32'h3001; A_LOAD_SIZE = 2'b10;
        tick();
        A_VALID = 1'b0; A_LOAD_RDEN = 1'b0;
        chk("mis cmdv", {31'd0, bus.MEM_CMD_VALID}, 32'd0);
        chk("mis stall", {31'd0, STALL}, 32'd0);
        chk("mis flag", {31'd0, M_MISALIGN}, 32'd1);
        chk("mis result", M_REG_D_V, 32'd0);
        chk("mis mvalid", {31'd0, M_VALID}, 32'd1);
        tick();
        chk("mis flag clr", {31'd0, M_MISALIGN}, 32'd0);

        // Reset while in RESP, then a late read response
        A_REG_D_V = 32'h0; A_PC = 32'h0;
        A_VALID = 1'b1; A_LOAD_RDEN = 1'b1; A_LOAD_ADDR = 32'h2008; A_LOAD_SIZE = 2'b10;
        bus.MEM_CMD_READY = 1'b1;
        tick();
        A_VALID = 1'b0; A_LOAD_RDEN = 1'b0;
        tick();
        chk("rr resp stall", {31'd0, STALL}, 32'd1);
        #1 RST = 1'b1;
        #1;
        chk("rr stall", {31'd0, STALL}, 32'd0);
        chk("rr cmdv", {31'd0, bus.MEM_CMD_VALID}, 32'd0);
        chk("rr mvalid", {31'd0, M_VALID}, 32'd0);
        chk("rr pc", M_PC, 32'd0);
        chk("rr result", M_REG_D_V, 32'd0);
        #1 RST = 1'b0;
        bus.MEM_RD_VALID = 1'b1; bus.MEM_RD_DATA = 32'hCAFE_F00D;
        tick();
        bus.MEM_RD_VALID = 1'b0;
        chk("late stall", {31'd0, STALL}, 32'd0);
        chk("late cmdv", {31'd0, bus.MEM_CMD_VALID}, 32'd0);
        chk("late mvalid", {31'd0, M_VALID}, 32'd0);
        chk("late result", M_REG_D_V, 32'd0);

        chk("sb queue empty", cmd_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
